alu: RTL and testbench
======================

# alu

Two-operand integer add/subtract unit for the CORDIC vectoring datapath. It produces the x/y/z update sums and differences for each micro-rotation. Operands are combined in two's-complement arithmetic of parameterised width. The result is registered, so the unit slots into the clocked iteration pipeline with a fixed one-cycle latency.

## Interface
- WORD_LENGTH, 16, operand and result width in bits (minimum 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands and opcode valid this cycle.
- ALU_operation  input  1  0 = add (A + B), 1 = subtract (A − B).
- A  input  WORD_LENGTH  first operand.
- B  input  WORD_LENGTH  second operand.
- AlU_out  output  WORD_LENGTH  registered result.
- out_valid  output  1  AlU_out updated with a new result this cycle.
- flag_z  output  1  result is zero (ALU_FLAGS_EN only).
- flag_n  output  1  result MSB (ALU_FLAGS_EN only).
- flag_c  output  1  add: carry out; subtract: borrow, i.e. A < B unsigned (ALU_FLAGS_EN only).
- flag_v  output  1  signed two's-complement overflow (ALU_FLAGS_EN only).

## Operation
- Add: AlU_out = (A + B) mod 2^WORD_LENGTH.
- Subtract: AlU_out = (A − B) mod 2^WORD_LENGTH, computed as A + ~B + 1.
- Overflow wraps silently; no saturation.
- Bit patterns are identical whether the operands are read as signed or unsigned. Only the flags distinguish the two interpretations.
- Overflow rule:
  - Add: flag_v = 1 when A and B share a sign and the result sign differs.
  - Subtract: flag_v = 1 when A and B differ in sign and the result sign differs from A.
- in_valid = 0: AlU_out and the flags hold their previous values; out_valid = 0 next cycle.
- No other state and no state machine. The unit is a registered combinational datapath.

## Timing
- Latency: 1 cycle. Inputs sampled on the rising edge with in_valid = 1 appear on AlU_out, with out_valid = 1, after that same edge.
- Throughput: one operation per cycle. Back-to-back in_valid pulses give back-to-back results.
- No backpressure; the consumer must accept every out_valid pulse.
- Reset (rst_n low, asynchronous, any time, including mid-stream):
  - AlU_out = 0, out_valid = 0, all flags = 0, immediately.
  - An operation sampled in the same cycle as reset assertion is discarded.
- After rst_n deasserts, the first rising edge with in_valid = 1 produces a result.
- Changing ALU_operation, A or B while in_valid = 0 has no effect on the outputs.

## Configuration
- ALU_FLAGS_EN defined: flag_z, flag_n, flag_c and flag_v exist and are registered alongside AlU_out, with identical latency, hold and reset behaviour.
- ALU_FLAGS_EN undefined: the four flag ports and their logic are absent. AlU_out and out_valid behave identically in both builds.

## Test plan
- Reset: drive rst_n low mid-stream with in_valid = 1 -> AlU_out = 0, out_valid = 0 immediately; no result appears for the op sampled that cycle.
- Adds (WORD_LENGTH = 16):
  - 16 + 32 -> 48.
  - 21 + 18 -> 39.
  - 0xFFFF + 1 -> 0x0000, with flag_c = 1, flag_z = 1, flag_v = 0.
  - 0x7FFF + 1 -> 0x8000, with flag_v = 1, flag_n = 1.
- Subtracts:
  - 128 − 17 -> 111.
  - 64 − 24 -> 40.
  - 72 − 25 -> 47.
  - 20 − 20 -> 0, with flag_z = 1, flag_c = 0.
- Negative result: 45 − 90 -> 0xFFD3 (65491), with flag_n = 1, flag_c = 1, flag_v = 0.
- Handshake:
  - in_valid pulse -> out_valid high exactly one cycle later.
  - in_valid = 0 with changing A/B -> AlU_out held, out_valid = 0.
  - Continuous in_valid -> one result per cycle, in order.
- Build without ALU_FLAGS_EN -> all AlU_out values above unchanged.

Source files
------------

// File: rtl/alu.sv
// Two-operand add/subtract unit for the CORDIC vectoring datapath.
// The result is registered, so the unit has a fixed one-cycle latency.
// Subtraction is computed as A + ~B + 1 so that one adder serves both operations.
// Optional build macro: ALU_FLAGS_EN adds the registered zero, negative,
// carry/borrow and signed-overflow flags.
module alu #(
   parameter int WORD_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   ALU_operation,
   input  logic [WORD_LENGTH-1:0] A,
   input  logic [WORD_LENGTH-1:0] B,
   output logic [WORD_LENGTH-1:0] AlU_out,
   output logic                   out_valid
`ifdef ALU_FLAGS_EN
   ,
   output logic                   flag_z,
   output logic                   flag_n,
   output logic                   flag_c,
   output logic                   flag_v
`endif
);

   localparam int MSB = WORD_LENGTH - 1;

   logic [WORD_LENGTH-1:0] b_eff;
   logic [WORD_LENGTH-1:0] result;

   // Subtract inverts B here; the +1 enters as the adder carry-in below.
   assign b_eff = ALU_operation ? ~B : B;

`ifdef ALU_FLAGS_EN
   logic [WORD_LENGTH:0] sum_ext;
   logic                 carry_out;
   logic                 z_next;
   logic                 n_next;
   logic                 c_next;
   logic                 v_next;

   // One extra bit on the adder to expose the carry out.
   assign sum_ext   = {1'b0, A} + {1'b0, b_eff} + {{WORD_LENGTH{1'b0}}, ALU_operation};
   assign result    = sum_ext[MSB:0];
   assign carry_out = sum_ext[WORD_LENGTH];

   // Flag values derived from the combinational result.
   // For subtract, A + ~B + 1 carries out exactly when A >= B (unsigned), so
   // the borrow is the inverted carry. Overflow uses the effective second
   // operand, which covers both operations with one rule.
   always_comb begin
      z_next = (result == '0);
      n_next = result[MSB];
      c_next = carry_out ^ ALU_operation;
      v_next = (A[MSB] == b_eff[MSB]) && (result[MSB] != A[MSB]);
   end

   // Flags are registered alongside the result, with the same hold and reset behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (in_valid) begin
         flag_z <= z_next;
         flag_n <= n_next;
         flag_c <= c_next;
         flag_v <= v_next;
      end
   end
`else
   // Without flags the carry out is not needed, so the adder is word-wide only.
   assign result = A + b_eff + {{(WORD_LENGTH-1){1'b0}}, ALU_operation};
`endif

   // Result register: it loads on a valid operation and otherwise holds its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AlU_out <= '0;
      end else if (in_valid) begin
         AlU_out <= result;
      end
   end

   // out_valid pulses for exactly the cycle after each accepted operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu. Expected results come from an independent
// integer model. They are queued when an operation is driven and are checked
// when out_valid reports the result. Define ALU_FLAGS_EN to check the flags as well.
module tb_alu;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         ALU_operation;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] AlU_out;
   logic         out_valid;
`ifdef ALU_FLAGS_EN
   logic         flag_z;
   logic         flag_n;
   logic         flag_c;
   logic         flag_v;
`endif

   typedef struct {
      logic [W-1:0] data;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb[$];

   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_en   = 0;

   alu #(.WORD_LENGTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .ALU_operation (ALU_operation),
      .A             (A),
      .B             (B),
      .AlU_out       (AlU_out),
      .out_valid     (out_valid)
`ifdef ALU_FLAGS_EN
      ,
      .flag_z        (flag_z),
      .flag_n        (flag_n),
      .flag_c        (flag_c),
      .flag_v        (flag_v)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Integer reference model, independent of the adder structure.
   function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   ua, ub, sa, sb_i, sr;
      ua   = int'({16'b0, a});
      ub   = int'({16'b0, b});
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
      sr   = op ? (sa - sb_i) : (sa + sb_i);
      e.data = op ? (a - b) : (a + b);
      e.z    = (e.data == '0);
      e.n    = e.data[W-1];
      e.c    = op ? (ua < ub) : ((ua + ub) > 65535);
      e.v    = (sr > 32767) || (sr < -32768);
      return e;
   endfunction

   // Drive one cycle of stimulus on the falling edge; queue the expected result if it is valid.
   task automatic drive(input logic v, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      in_valid      = v;
      ALU_operation = op;
      A             = a;
      B             = b;
      if (v) sb.push_back(model(op, a, b));
   endtask

   // Monitor: 1 time unit after each rising edge, check the handshake, the hold behaviour and the scoreboard.
   initial begin
      logic         iv;
      logic [W-1:0] last_out;
      exp_t         e;
      last_out = '0;
      forever begin
         @(posedge clk);
         iv = in_valid && rst_n;
         #1;
         if (!rst_n) begin
            last_out = '0;
         end else if (mon_en) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, iv});
            if (out_valid) begin
               if (sb.size() == 0) begin
                  check("sb_empty", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("data", {16'b0, AlU_out}, {16'b0, e.data});
`ifdef ALU_FLAGS_EN
                  check("flag_z", {31'b0, flag_z}, {31'b0, e.z});
                  check("flag_n", {31'b0, flag_n}, {31'b0, e.n});
                  check("flag_c", {31'b0, flag_c}, {31'b0, e.c});
                  check("flag_v", {31'b0, flag_v}, {31'b0, e.v});
`endif
               end
            end else begin
               check("hold", {16'b0, AlU_out}, {16'b0, last_out});
            end
            last_out = AlU_out;
         end
      end
   end

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int guard;
      vecs = '{
         '{1'b0, 16'd16,    16'd32},
         '{1'b0, 16'd21,    16'd18},
         '{1'b0, 16'hFFFF,  16'd1},
         '{1'b0, 16'h7FFF,  16'd1},
         '{1'b1, 16'd128,   16'd17},
         '{1'b1, 16'd64,    16'd24},
         '{1'b1, 16'd72,    16'd25},
         '{1'b1, 16'd20,    16'd20},
         '{1'b1, 16'd45,    16'd90},
         '{1'b0, 16'h8000,  16'h8000},
         '{1'b1, 16'h8000,  16'd1},
         '{1'b1, 16'h7FFF,  16'hFFFF}
      };

      rst_n = 1'b0;
      in_valid = 1'b0;
      ALU_operation = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", {16'b0, AlU_out}, 32'd0);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1;

      // Directed vectors, applied back-to-back.
      foreach (vecs[i]) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);

      // Isolated pulse, then idle cycles while A/B/op change; the result must hold.
      drive(1'b1, 1'b0, 16'd1000, 16'd234);
      for (int i = 0; i < 4; i++) drive(1'b0, i[0], 16'(i * 977 + 5), 16'(i * 311 + 9));

      // Randomised continuous stream plus a few gapped operations.
      for (int i = 0; i < 40; i++)
         drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom));
      drive(1'b0, 1'b0, '0, '0);
      drive(1'b0, 1'b0, '0, '0);

      // Reset mid-stream: the operation sampled during reset must be discarded.
      drive(1'b1, 1'b0, 16'd300, 16'd400);
      drive(1'b1, 1'b1, 16'd5, 16'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", {16'b0, AlU_out}, 32'd0);
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      check("rst_discard_out", {16'b0, AlU_out}, 32'd0);
      check("rst_discard_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 16'd77, 16'd11);

      // The first valid operation after reset produces a result.
      drive(1'b1, 1'b1, 16'd128, 16'd17);
      drive(1'b1, 1'b0, 16'd16, 16'd32);
      drive(1'b0, 1'b0, '0, '0);

      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("drain", sb.size(), 32'd0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
